zap_cp15_ctrl: RTL and testbench

- CP15 system-control coprocessor; sits directly downstream of the coprocessor predecode stage.
- Consumes the registered coprocessor word/valid pair from predecode and executes MRC/MCR.
- Moves data between the physical register file and CP15 registers (c0/c1/c2/c3/c5/c6), and sequences cache/TLB maintenance (c7/c8).
- Returns a one-cycle done pulse that releases the predecode stall.

---
 rtl/zap_cp15_pkg.sv | 70 +++++++
 rtl/zap_cp15_translate.sv | 26 ++
 rtl/zap_cp15_ctrl.sv | 175 +++++++++++++++++
 tb/tb_zap_cp15_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_cp15_pkg.sv
// Shared CP15 types: FSM states, CRn/CRm codes, c1 reset value and the MRC/MCR word layout.
// Also holds the banked physical-register layout used by zap_cp15_translate.
package zap_cp15_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_CAP,
        S_WR_CORE,
        S_MAINT,
        S_DONE
    } cp15_state_t;

    localparam logic [3:0] C0_ID    = 4'd0;
    localparam logic [3:0] C1_CTRL  = 4'd1;
    localparam logic [3:0] C2_TTBR  = 4'd2;
    localparam logic [3:0] C3_DAC   = 4'd3;
    localparam logic [3:0] C5_FSR   = 4'd5;
    localparam logic [3:0] C6_FAR   = 4'd6;
    localparam logic [3:0] C7_CACHE = 4'd7;
    localparam logic [3:0] C8_TLB   = 4'd8;

    localparam logic [3:0] CRM_INV_I   = 4'd5;
    localparam logic [3:0] CRM_INV_D   = 4'd6;
    localparam logic [3:0] CRM_INV_ALL = 4'd7;

    localparam logic [31:0] C1_RESET = 32'h0000_0078;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    // Banked registers sit above R0-R15 and the RAZ slot at index 16.
    localparam int PHY_FIQ_R8  = 17;
    localparam int PHY_IRQ_R13 = 24;
    localparam int PHY_SVC_R13 = 26;
    localparam int PHY_UND_R13 = 28;
    localparam int PHY_ABT_R13 = 30;

    typedef struct packed {
        logic [3:0] cond;
        logic [3:0] op;
        logic [2:0] opc1;
        logic       l;
        logic [3:0] crn;
        logic [3:0] rd;
        logic [3:0] cpn;
        logic [2:0] opc2;
        logic       cprt;
        logic [3:0] crm;
    } cp_word_t;

    // {icache, dcache} invalidate mask for a maintenance CRm; zero means unsupported.
    function automatic logic [1:0] maint_mask(input logic [3:0] crm);
        case (crm)
            CRM_INV_I:   return 2'b10;
            CRM_INV_D:   return 2'b01;
            CRM_INV_ALL: return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

    function automatic logic is_reg_crn(input logic [3:0] crn);
        return crn inside {C0_ID, C1_CTRL, C2_TTBR, C3_DAC, C5_FSR, C6_FAR};
    endfunction

endpackage

// File: rtl/zap_cp15_translate.sv
// Combinational architectural (Rd, mode) to physical register index mapping.
module zap_cp15_translate
    import zap_cp15_pkg::*;
#(
    parameter int PHY_REGS = 46
)(
    input  logic [3:0]                  rd,
    input  logic [4:0]                  mode,
    output logic [$clog2(PHY_REGS)-1:0] index
);

    localparam int IW = $clog2(PHY_REGS);

    always_comb begin
        index = IW'(rd);
        case (mode)
            MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14)  index = IW'(PHY_FIQ_R8  + int'(rd) - 8);
            MODE_IRQ: if (rd == 4'd13 || rd == 4'd14) index = IW'(PHY_IRQ_R13 + int'(rd) - 13);
            MODE_SVC: if (rd == 4'd13 || rd == 4'd14) index = IW'(PHY_SVC_R13 + int'(rd) - 13);
            MODE_UND: if (rd == 4'd13 || rd == 4'd14) index = IW'(PHY_UND_R13 + int'(rd) - 13);
            MODE_ABT: if (rd == 4'd13 || rd == 4'd14) index = IW'(PHY_ABT_R13 + int'(rd) - 13);
            default: ;
        endcase
    end

endmodule

// File: rtl/zap_cp15_ctrl.sv
// CP15 controller: executes MRC/MCR against c0-c6 and sequences c7/c8 maintenance.
// Define ZAP_CP15_UNDEF_EN to add o_cp_undef, flagging unsupported requests with o_cp_done.
module zap_cp15_ctrl
    import zap_cp15_pkg::*;
#(
    parameter int          PHY_REGS = 46,
    parameter logic [31:0] CPU_ID   = 32'h4156_0000
)(
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_cp_dav,
    input  logic [31:0]                 i_cp_word,
    input  logic [4:0]                  i_cpsr_mode,
    output logic                        o_cp_done,
    output logic                        o_reg_rd_en,
    output logic                        o_reg_wr_en,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_index,
    output logic [31:0]                 o_reg_wr_data,
    input  logic [31:0]                 i_reg_rd_data,
    output logic [31:0]                 o_cp1_ctrl,
    output logic [31:0]                 o_ttbr,
    output logic [31:0]                 o_dac,
    output logic [31:0]                 o_fsr,
    output logic [31:0]                 o_far,
    output logic [1:0]                  o_cache_inv_req,
    output logic                        o_tlb_inv_req,
    input  logic                        i_maint_ack,
    input  logic                        i_fault_we,
    input  logic [31:0]                 i_fsr_din,
    input  logic [31:0]                 i_far_din
`ifdef ZAP_CP15_UNDEF_EN
    ,output logic                       o_cp_undef
`endif
);

    localparam int IW = $clog2(PHY_REGS);

    // Handshake: i_cp_dav is a level held until o_cp_done; a request is taken only while armed,
    // and armed returns once dav is sampled low, so a dav left high never re-issues.
    cp_word_t    w_in;
    cp15_state_t state;
    logic        armed;
    logic [3:0]  crn_q;
    logic [IW-1:0] xlat_idx;
    logic [31:0] mrc_data;
    logic [1:0]  maint;
    logic        is_cprt;
    logic        unsup;
    logic        unused_fields;

    assign w_in          = i_cp_word;
    assign maint         = maint_mask(w_in.crm);
    assign is_cprt       = (w_in.op == 4'hE) && w_in.cprt && (w_in.cpn == 4'hF);
    assign unused_fields = ^{w_in.cond, w_in.opc1, w_in.opc2};

    always_comb begin
        if (!is_cprt)
            unsup = 1'b1;
        else if (w_in.l)
            unsup = !is_reg_crn(w_in.crn);
        else
            unsup = !(is_reg_crn(w_in.crn) ||
                      ((w_in.crn == C7_CACHE || w_in.crn == C8_TLB) && maint != 2'b00));
    end

    always_comb begin
        mrc_data = 32'h0;
        case (w_in.crn)
            C0_ID:   mrc_data = CPU_ID;
            C1_CTRL: mrc_data = o_cp1_ctrl;
            C2_TTBR: mrc_data = o_ttbr;
            C3_DAC:  mrc_data = o_dac;
            C5_FSR:  mrc_data = o_fsr;
            C6_FAR:  mrc_data = o_far;
            default: mrc_data = 32'h0;
        endcase
    end

    zap_cp15_translate #(.PHY_REGS(PHY_REGS)) u_translate (
        .rd    (w_in.rd),
        .mode  (i_cpsr_mode),
        .index (xlat_idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state           <= S_IDLE;
            armed           <= 1'b1;
            crn_q           <= 4'h0;
            o_cp_done       <= 1'b0;
            o_reg_rd_en     <= 1'b0;
            o_reg_wr_en     <= 1'b0;
            o_reg_index     <= '0;
            o_reg_wr_data   <= 32'h0;
            o_cp1_ctrl      <= C1_RESET;
            o_ttbr          <= 32'h0;
            o_dac           <= 32'h0;
            o_fsr           <= 32'h0;
            o_far           <= 32'h0;
            o_cache_inv_req <= 2'b00;
            o_tlb_inv_req   <= 1'b0;
`ifdef ZAP_CP15_UNDEF_EN
            o_cp_undef      <= 1'b0;
`endif
        end else begin
            o_cp_done   <= 1'b0;
            o_reg_rd_en <= 1'b0;
            o_reg_wr_en <= 1'b0;
`ifdef ZAP_CP15_UNDEF_EN
            o_cp_undef  <= 1'b0;
`endif
            if (!i_cp_dav)
                armed <= 1'b1;
            // MMU fault capture; an MCR landing on c5/c6 below overrides it.
            if (i_fault_we) begin
                o_fsr <= i_fsr_din;
                o_far <= i_far_din;
            end
            case (state)
                S_IDLE: if (i_cp_dav && armed) begin
                    armed <= 1'b0;
                    crn_q <= w_in.crn;
                    if (unsup) begin
                        state     <= S_DONE;
                        o_cp_done <= 1'b1;
`ifdef ZAP_CP15_UNDEF_EN
                        o_cp_undef <= 1'b1;
`endif
                    end else if (w_in.l) begin
                        state         <= S_WR_CORE;
                        o_reg_wr_en   <= (w_in.rd != 4'hF);
                        o_reg_index   <= xlat_idx;
                        o_reg_wr_data <= mrc_data;
                    end else if (is_reg_crn(w_in.crn)) begin
                        state       <= S_RD_REQ;
                        o_reg_rd_en <= 1'b1;
                        o_reg_index <= xlat_idx;
                    end else begin
                        state <= S_MAINT;
                        if (w_in.crn == C7_CACHE)
                            o_cache_inv_req <= maint;
                        else
                            o_tlb_inv_req <= 1'b1;
                    end
                end
                S_RD_REQ: state <= S_RD_CAP;
                S_RD_CAP: begin
                    case (crn_q)
                        C1_CTRL: o_cp1_ctrl <= i_reg_rd_data;
                        C2_TTBR: o_ttbr     <= i_reg_rd_data;
                        C3_DAC:  o_dac      <= i_reg_rd_data;
                        C5_FSR:  o_fsr      <= i_reg_rd_data;
                        C6_FAR:  o_far      <= i_reg_rd_data;
                        default: ;
                    endcase
                    state     <= S_DONE;
                    o_cp_done <= 1'b1;
                end
                S_WR_CORE: begin
                    state     <= S_DONE;
                    o_cp_done <= 1'b1;
                end
                S_MAINT: if (i_maint_ack) begin
                    o_cache_inv_req <= 2'b00;
                    o_tlb_inv_req   <= 1'b0;
                    state           <= S_DONE;
                    o_cp_done       <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zap_cp15_ctrl.sv
// Scoreboard bench for zap_cp15_ctrl: directed MRC/MCR/maintenance vectors with hand-computed results.
module tb_zap_cp15_ctrl;

    localparam int IW = 6;
`ifdef ZAP_CP15_UNDEF_EN
    localparam bit UNDEF_ON = 1'b1;
`else
    localparam bit UNDEF_ON = 1'b0;
`endif
    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_cp_dav = 1'b0;
    logic [31:0]   i_cp_word = 32'h0;
    logic [4:0]    i_cpsr_mode = M_USR;
    logic          o_cp_done, o_reg_rd_en, o_reg_wr_en;
    logic [IW-1:0] o_reg_index;
    logic [31:0]   o_reg_wr_data;
    logic [31:0]   i_reg_rd_data = 32'hDEAD_BEEF;
    logic [31:0]   o_cp1_ctrl, o_ttbr, o_dac, o_fsr, o_far;
    logic [1:0]    o_cache_inv_req;
    logic          o_tlb_inv_req;
    logic          i_maint_ack = 1'b0;
    logic          i_fault_we = 1'b0;
    logic [31:0]   i_fsr_din = 32'h0;
    logic [31:0]   i_far_din = 32'h0;
`ifdef ZAP_CP15_UNDEF_EN
    logic          o_cp_undef;
`endif

    zap_cp15_ctrl dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cp_dav(i_cp_dav), .i_cp_word(i_cp_word),
        .i_cpsr_mode(i_cpsr_mode), .o_cp_done(o_cp_done), .o_reg_rd_en(o_reg_rd_en),
        .o_reg_wr_en(o_reg_wr_en), .o_reg_index(o_reg_index), .o_reg_wr_data(o_reg_wr_data),
        .i_reg_rd_data(i_reg_rd_data), .o_cp1_ctrl(o_cp1_ctrl), .o_ttbr(o_ttbr), .o_dac(o_dac),
        .o_fsr(o_fsr), .o_far(o_far), .o_cache_inv_req(o_cache_inv_req),
        .o_tlb_inv_req(o_tlb_inv_req), .i_maint_ack(i_maint_ack), .i_fault_we(i_fault_we),
        .i_fsr_din(i_fsr_din), .i_far_din(i_far_din)
`ifdef ZAP_CP15_UNDEF_EN
        , .o_cp_undef(o_cp_undef)
`endif
    );

    // Clock / cycle counter
    always #5 i_clk = ~i_clk;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_exp_cnt = 0;
    logic [99:0] done_q[$];   // {undef, cache_req, tlb_req, cp1, ttbr, cycle}
    logic [71:0] strobe_q[$]; // {kind, index, data, cycle}; kind 1=read 2=write
    logic [31:0] m_cp1 = 32'h78;
    logic [31:0] m_ttbr = 32'h0;
    logic [31:0] rf[46];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic l, input logic [3:0] cpn, input logic [3:0] crn,
                                       input logic [3:0] rd, input logic [3:0] crm);
        return {4'hE, 4'hE, 3'b000, l, crn, rd, cpn, 3'b000, 1'b1, crm};
    endfunction

    // Register file model: data is valid the cycle after the read request.
    bit            rd_pend = 1'b0;
    logic [IW-1:0] pend_idx = '0;
    always @(negedge i_clk) begin
        i_reg_rd_data = rd_pend ? rf[pend_idx] : 32'hDEAD_BEEF;
        rd_pend = o_reg_rd_en;
        pend_idx = o_reg_index;
    end

    // Monitor
    logic        act_u;
    logic [99:0] done_act, done_exp;
    logic [71:0] stb_act, stb_exp;
    always @(negedge i_clk) begin
`ifdef ZAP_CP15_UNDEF_EN
        act_u = o_cp_undef;
`else
        act_u = 1'b0;
`endif
        if (o_cp_done) begin
            done_cnt++;
            done_act = {act_u, o_cache_inv_req, o_tlb_inv_req, o_cp1_ctrl, o_ttbr, 32'(cyc)};
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                done_exp = done_q.pop_front();
                check("done", done_act, done_exp);
            end
        end
        if (o_reg_rd_en || o_reg_wr_en) begin
            stb_act = o_reg_rd_en ? {2'd1, o_reg_index, 32'h0, 32'(cyc)}
                                  : {2'd2, o_reg_index, o_reg_wr_data, 32'(cyc)};
            if (strobe_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_strobe: got %0h expected none", stb_act);
            end else begin
                stb_exp = strobe_q.pop_front();
                check("reg_strobe", stb_act, stb_exp);
            end
        end
    end

    // Driver: issue one request, hold dav until done, optionally ack/fault/extra hold.
    task automatic run_op(input logic [31:0] word, input logic [4:0] mode, input int lat,
                          input logic undef, input int skind, input logic [IW-1:0] sidx,
                          input logic [31:0] sdata, input int ack_at, input logic [1:0] lvl_cache,
                          input logic lvl_tlb, input int fault_at, input int hold);
        int  base;
        bit  seen;
        seen = 1'b0;
        @(negedge i_clk);
        base = cyc;
        i_cp_word = word;
        i_cpsr_mode = mode;
        i_cp_dav = 1'b1;
        done_q.push_back({UNDEF_ON ? undef : 1'b0, 2'b00, 1'b0, m_cp1, m_ttbr, 32'(base + lat)});
        done_exp_cnt++;
        if (skind != 0)
            strobe_q.push_back({2'(skind), sidx, (skind == 2) ? sdata : 32'h0, 32'(base + 1)});
        for (int n = 1; n <= 200; n++) begin
            @(negedge i_clk);
            if (ack_at > 0 && n <= ack_at) begin
                check("maint_cache_level", o_cache_inv_req, lvl_cache);
                check("maint_tlb_level", o_tlb_inv_req, lvl_tlb);
            end
            i_maint_ack = (n == ack_at);
            i_fault_we = (n == fault_at);
            if (o_cp_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected one by cycle %0d", base + lat);
        end
        i_maint_ack = 1'b0;
        i_fault_we = 1'b0;
        i_cp_dav = (hold > 0);
        repeat (hold) @(negedge i_clk);
        i_cp_dav = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 46; i++) rf[i] = 32'hA500_0000 | 32'(i);
        rf[1]  = 32'h0000_4000;
        rf[2]  = 32'h5555_0001;
        rf[4]  = 32'h0000_00F5;
        rf[5]  = 32'h0000_1005;
        rf[30] = 32'hFA11_0000;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_done", o_cp_done, 1'b0);
        check("rst_rd_en", o_reg_rd_en, 1'b0);
        check("rst_wr_en", o_reg_wr_en, 1'b0);
        check("rst_index", o_reg_index, 6'd0);
        check("rst_wr_data", o_reg_wr_data, 32'h0);
        check("rst_cp1", o_cp1_ctrl, 32'h0000_0078);
        check("rst_ttbr", o_ttbr, 32'h0);
        check("rst_dac", o_dac, 32'h0);
        check("rst_fsr", o_fsr, 32'h0);
        check("rst_far", o_far, 32'h0);
        check("rst_cache_req", o_cache_inv_req, 2'b00);
        check("rst_tlb_req", o_tlb_inv_req, 1'b0);
        i_reset_n = 1'b1;

        // MCR c2 from R1 in SVC
        m_ttbr = 32'h0000_4000;
        run_op(mk(0, 4'd15, 4'd2, 4'd1, 4'd0), M_SVC, 3, 0, 1, 6'd1, 0, 0, 2'b00, 0, 0, 0);
        check("ttbr_after_mcr", o_ttbr, 32'h0000_4000);

        // MRC c1 to FIQ R13 (banked index 22)
        run_op(mk(1, 4'd15, 4'd1, 4'd13, 4'd0), M_FIQ, 2, 0, 2, 6'd22, 32'h78, 0, 2'b00, 0, 0, 0);
        // MRC c2 to user R3
        run_op(mk(1, 4'd15, 4'd2, 4'd3, 4'd0), M_USR, 2, 0, 2, 6'd3, 32'h4000, 0, 2'b00, 0, 0, 0);
        // MCR c1 from R5 then MRC c1 to IRQ R14 (index 25)
        m_cp1 = 32'h0000_1005;
        run_op(mk(0, 4'd15, 4'd1, 4'd5, 4'd0), M_USR, 3, 0, 1, 6'd5, 0, 0, 2'b00, 0, 0, 0);
        run_op(mk(1, 4'd15, 4'd1, 4'd14, 4'd0), M_IRQ, 2, 0, 2, 6'd25, 32'h1005, 0, 2'b00, 0, 0, 0);
        // MRC c0 to R15: write suppressed
        run_op(mk(1, 4'd15, 4'd0, 4'd15, 4'd0), M_SVC, 2, 0, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0);
        // MCR c6 from ABT R13 (index 30)
        run_op(mk(0, 4'd15, 4'd6, 4'd13, 4'd0), M_ABT, 3, 0, 1, 6'd30, 0, 0, 2'b00, 0, 0, 0);
        check("far_after_mcr", o_far, 32'hFA11_0000);

        // Maintenance: c7 both caches, ack after 10 cycles; c8 TLB, ack after 3
        run_op(mk(0, 4'd15, 4'd7, 4'd0, 4'd7), M_SVC, 11, 0, 0, 6'd0, 0, 10, 2'b11, 0, 0, 0);
        run_op(mk(0, 4'd15, 4'd8, 4'd0, 4'd5), M_SVC, 4, 0, 0, 6'd0, 0, 3, 2'b00, 1, 0, 0);

        // dav held 20 cycles after done: no retrigger; next request accepted after dav=0
        run_op(mk(0, 4'd15, 4'd3, 4'd2, 4'd0), M_USR, 3, 0, 1, 6'd2, 0, 0, 2'b00, 0, 0, 20);
        check("dac_after_mcr", o_dac, 32'h5555_0001);
        run_op(mk(0, 4'd15, 4'd3, 4'd8, 4'd0), M_FIQ, 3, 0, 1, 6'd17, 0, 0, 2'b00, 0, 0, 0);
        check("dac_fiq_r8", o_dac, 32'hA500_0011);

        // Unsupported: cp14, CDP form, c7 with unknown CRm
        run_op(mk(1, 4'd14, 4'd1, 4'd0, 4'd0), M_USR, 1, 1, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0);
        w = mk(0, 4'd15, 4'd2, 4'd1, 4'd0);
        w[4] = 1'b0;
        run_op(w, M_USR, 1, 1, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0);
        run_op(mk(0, 4'd15, 4'd7, 4'd0, 4'd4), M_USR, 1, 1, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0);
        check("ttbr_untouched", o_ttbr, 32'h0000_4000);

        // Fault capture while idle
        @(negedge i_clk);
        i_fault_we = 1'b1; i_fsr_din = 32'h0000_0017; i_far_din = 32'h1234_5678;
        @(negedge i_clk);
        i_fault_we = 1'b0;
        check("fault_fsr", o_fsr, 32'h0000_0017);
        check("fault_far", o_far, 32'h1234_5678);

        // MCR c5 colliding with a fault strobe: MCR wins for c5, c6 takes the fault address
        i_fsr_din = 32'h0000_00AA; i_far_din = 32'h0BAD_F00D;
        run_op(mk(0, 4'd15, 4'd5, 4'd4, 4'd0), M_USR, 3, 0, 1, 6'd4, 0, 0, 2'b00, 0, 2, 0);
        check("fsr_mcr_priority", o_fsr, 32'h0000_00F5);
        check("far_fault_same_cycle", o_far, 32'h0BAD_F00D);

        // Reset while in MAINT
        @(negedge i_clk);
        i_cp_word = mk(0, 4'd15, 4'd7, 4'd0, 4'd6);
        i_cp_dav = 1'b1;
        repeat (3) @(negedge i_clk);
        check("maint_dcache_req", o_cache_inv_req, 2'b01);
        i_reset_n = 1'b0;
        i_cp_dav = 1'b0;
        @(negedge i_clk);
        check("rst_maint_cache", o_cache_inv_req, 2'b00);
        check("rst_maint_tlb", o_tlb_inv_req, 1'b0);
        check("rst_maint_cp1", o_cp1_ctrl, 32'h0000_0078);
        check("rst_maint_done", o_cp_done, 1'b0);
        check("rst_maint_fsr", o_fsr, 32'h0);
        i_reset_n = 1'b1;
        m_cp1 = 32'h78;
        m_ttbr = 32'h0;
        repeat (5) @(negedge i_clk);
        run_op(mk(1, 4'd15, 4'd1, 4'd0, 4'd0), M_USR, 2, 0, 2, 6'd0, 32'h78, 0, 2'b00, 0, 0, 0);

        repeat (3) @(negedge i_clk);
        check("done_count", done_cnt, done_exp_cnt);
        check("done_q_empty", done_q.size(), 0);
        check("strobe_q_empty", strobe_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
